// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator for the ID stage. Decodes the immediate type from the
// opcode (or takes it from imm_type_in) and returns the XLEN-wide extended immediate.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int STAGES      = 1,
  parameter bit AUTO_DECODE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_type_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  localparam logic [2:0] TYPE_I     = 3'b000;
  localparam logic [2:0] TYPE_S     = 3'b001;
  localparam logic [2:0] TYPE_B     = 3'b010;
  localparam logic [2:0] TYPE_U     = 3'b011;
  localparam logic [2:0] TYPE_J     = 3'b100;
  localparam logic [2:0] TYPE_Z     = 3'b101;
  localparam logic [2:0] TYPE_SHAMT = 3'b110;
  localparam logic [2:0] TYPE_NONE  = 3'b111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
    $error("imm_gen_pipe: STAGES must be 1 or 2");
  end

  // Size casts of a signed operand sign-extend, unsigned operands zero-extend.
  function automatic logic [XLEN-1:0] form_imm(input logic [31:0] ins, input logic [2:0] t);
    logic [XLEN-1:0] r;
    r = '0;
    case (t)
      TYPE_I:     r = XLEN'($signed(ins[31:20]));
      TYPE_S:     r = XLEN'($signed({ins[31:25], ins[11:7]}));
      TYPE_B:     r = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      TYPE_U:     r = XLEN'($signed({ins[31:12], 12'h000}));
      TYPE_J:     r = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      TYPE_Z:     r = XLEN'(ins[19:15]);
      TYPE_SHAMT: r = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
      default:    r = '0;
    endcase
    return r;
  endfunction

  logic [2:0] dec_type;
  logic       dec_illegal;
  logic [2:0] sel_type;
  logic       sel_illegal;
  logic       in_fire;

  always_comb begin
    dec_type    = TYPE_NONE;
    dec_illegal = 1'b0;
    case (instr[6:0])
      OP_IMM:                     dec_type = (instr[13:12] == 2'b01) ? TYPE_SHAMT : TYPE_I;
      OP_LOAD, OP_JALR, OP_FENCE: dec_type = TYPE_I;
      OP_STORE:                   dec_type = TYPE_S;
      OP_BRANCH:                  dec_type = TYPE_B;
      OP_LUI, OP_AUIPC:           dec_type = TYPE_U;
      OP_JAL:                     dec_type = TYPE_J;
      OP_SYSTEM:                  dec_type = instr[14] ? TYPE_Z : TYPE_I;
      OP_REG:                     dec_type = TYPE_NONE;
      default: begin
        dec_type    = TYPE_NONE;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign sel_type    = AUTO_DECODE ? dec_type : imm_type_in;
  assign sel_illegal = AUTO_DECODE ? dec_illegal : 1'b0;

  if (STAGES == 1) begin : g_one_stage
    logic            st_valid;
    logic [XLEN-1:0] st_imm;
    logic [2:0]      st_type;
    logic            st_illegal;

    assign in_ready = (!st_valid || out_ready) && !flush;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_valid <= 1'b0;
      end else if (flush) begin
        st_valid <= 1'b0;
      end else begin
        st_valid <= in_fire || (st_valid && !out_ready);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_imm     <= '0;
        st_type    <= TYPE_NONE;
        st_illegal <= 1'b0;
      end else if (in_fire) begin
        st_imm     <= form_imm(instr, sel_type);
        st_type    <= sel_type;
        st_illegal <= sel_illegal;
      end
    end

    assign out_valid = st_valid;
    assign imm       = st_imm;
    assign imm_type  = st_type;
    assign illegal   = st_illegal;
  end else begin : g_two_stage
    logic            s1_valid;
    logic [31:7]     s1_payload;
    logic [2:0]      s1_type;
    logic            s1_illegal;
    logic            s2_valid;
    logic [XLEN-1:0] s2_imm;
    logic [2:0]      s2_type;
    logic            s2_illegal;
    logic            s2_free;
    logic            s1_advance;
    logic            s2_advance;

    // Opcode bits are not needed past decode, so stage 1 keeps only the immediate field.
    assign s2_advance = s2_valid && out_ready;
    assign s2_free    = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready   = (!s1_valid || s1_advance) && !flush;
    assign in_fire    = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        s1_valid <= in_fire || (s1_valid && !s1_advance);
        s2_valid <= s1_advance || (s2_valid && !s2_advance);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_payload <= '0;
        s1_type    <= TYPE_NONE;
        s1_illegal <= 1'b0;
      end else if (in_fire) begin
        s1_payload <= instr[31:7];
        s1_type    <= sel_type;
        s1_illegal <= sel_illegal;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_imm     <= '0;
        s2_type    <= TYPE_NONE;
        s2_illegal <= 1'b0;
      end else if (s1_advance) begin
        s2_imm     <= form_imm({s1_payload, 7'b0000000}, s1_type);
        s2_type    <= s1_type;
        s2_illegal <= s1_illegal;
      end
    end

    assign out_valid = s2_valid;
    assign imm       = s2_imm;
    assign imm_type  = s2_type;
    assign illegal   = s2_illegal;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: four configurations share one input stream, each tracked by
// an occupancy/age queue model plus directed vector tables and hand sequences.
module tb_imm_gen_pipe;

  localparam int N_DUT = 4;
  localparam int NV    = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_type_in;

  logic        in_ready_w  [N_DUT];
  logic        out_valid_w [N_DUT];
  logic        illegal_w   [N_DUT];
  logic [2:0]  type_w      [N_DUT];
  logic [31:0] imm_0, imm_1;
  logic [63:0] imm_2, imm_3;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .AUTO_DECODE(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .instr(instr), .imm_type_in(imm_type_in), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .imm(imm_0), .imm_type(type_w[0]), .illegal(illegal_w[0]));
  imm_gen_pipe #(.XLEN(32), .STAGES(2), .AUTO_DECODE(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .instr(instr), .imm_type_in(imm_type_in), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .imm(imm_1), .imm_type(type_w[1]), .illegal(illegal_w[1]));
  imm_gen_pipe #(.XLEN(64), .STAGES(1), .AUTO_DECODE(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[2]),
    .instr(instr), .imm_type_in(imm_type_in), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .imm(imm_2), .imm_type(type_w[2]), .illegal(illegal_w[2]));
  imm_gen_pipe #(.XLEN(64), .STAGES(2), .AUTO_DECODE(1'b0)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w[3]),
    .instr(instr), .imm_type_in(imm_type_in), .out_valid(out_valid_w[3]),
    .out_ready(out_ready), .imm(imm_3), .imm_type(type_w[3]), .illegal(illegal_w[3]));

  function automatic int xl_of(input int i);
    return (i < 2) ? 32 : 64;
  endfunction
  function automatic int st_of(input int i);
    return (i == 1 || i == 3) ? 2 : 1;
  endfunction
  function automatic bit ad_of(input int i);
    return (i != 3);
  endfunction
  function automatic logic [63:0] dut_imm(input int i);
    case (i)
      0:       return {32'd0, imm_0};
      1:       return {32'd0, imm_1};
      2:       return imm_2;
      default: return imm_3;
    endcase
  endfunction

  // Reference: opcode table and immediate values as plain signed arithmetic.
  task automatic ref_decode(input logic [31:0] ins, output logic [2:0] t, output logic ill);
    ill = 1'b0;
    case (ins[6:0])
      7'h13:               t = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 3'd6 : 3'd0;
      7'h03, 7'h67, 7'h0F: t = 3'd0;
      7'h23:               t = 3'd1;
      7'h63:               t = 3'd2;
      7'h37, 7'h17:        t = 3'd3;
      7'h6F:               t = 3'd4;
      7'h73:               t = ins[14] ? 3'd5 : 3'd0;
      7'h33:               t = 3'd7;
      default: begin
        t   = 3'd7;
        ill = 1'b1;
      end
    endcase
  endtask

  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] t, input int xlen);
    longint v;
    case (t)
      3'd0:    v = longint'($signed(ins[31:20]));
      3'd1:    v = longint'($signed({ins[31:25], ins[11:7]}));
      3'd2:    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3'd3:    v = longint'($signed(ins[31:12])) * 4096;
      3'd4:    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      3'd5:    v = longint'(ins[19:15]);
      3'd6:    v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    return (xlen == 32) ? {32'd0, v[31:0]} : v;
  endfunction

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
    logic [7:0]  age;
  } ent_t;

  ent_t mq  [N_DUT][4];
  int   occ [N_DUT];
  logic ir_s [N_DUT];
  logic ov_s [N_DUT];
  logic        cur_v, cur_ordy, cur_fl;
  logic [31:0] cur_ins;
  logic [2:0]  cur_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ready(input int i);
    return !flush && (occ[i] < st_of(i) || out_ready);
  endfunction
  function automatic logic model_valid(input int i);
    return (occ[i] > 0) && (int'(mq[i][0].age) >= st_of(i));
  endfunction

  // Called right after a falling edge: apply inputs, then compare all DUTs with the model.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] t,
                       input logic ordy, input logic fl);
    in_valid = v; instr = ins; imm_type_in = t; out_ready = ordy; flush = fl;
    cur_v = v; cur_ins = ins; cur_t = t; cur_ordy = ordy; cur_fl = fl;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      ir_s[i] = model_ready(i);
      ov_s[i] = model_valid(i);
      chk($sformatf("dut%0d in_ready", i), 64'(in_ready_w[i]), 64'(ir_s[i]));
      chk($sformatf("dut%0d out_valid", i), 64'(out_valid_w[i]), 64'(ov_s[i]));
      if (ov_s[i]) begin
        chk($sformatf("dut%0d imm", i), dut_imm(i), mq[i][0].imm);
        chk($sformatf("dut%0d imm_type", i), 64'(type_w[i]), 64'(mq[i][0].typ));
        chk($sformatf("dut%0d illegal", i), 64'(illegal_w[i]), 64'(mq[i][0].ill));
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      if (cur_fl) begin
        occ[i] = 0;
      end else begin
        for (int j = 0; j < occ[i]; j++)
          if (mq[i][j].age != 8'hFF) mq[i][j].age = mq[i][j].age + 8'd1;
        if (ov_s[i] && cur_ordy) begin
          for (int j = 0; j < 3; j++) mq[i][j] = mq[i][j+1];
          occ[i]--;
        end
        if (cur_v && ir_s[i] && occ[i] < 4) begin
          ent_t e;
          if (ad_of(i)) ref_decode(cur_ins, e.typ, e.ill);
          else begin
            e.typ = cur_t;
            e.ill = 1'b0;
          end
          e.imm = ref_imm(cur_ins, e.typ, xl_of(i));
          e.age = 8'd1;
          mq[i][occ[i]] = e;
          occ[i]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    for (int i = 0; i < N_DUT; i++) begin
      chk($sformatf("%s dut%0d out_valid", tag, i), 64'(out_valid_w[i]), 64'd0);
      chk($sformatf("%s dut%0d imm", tag, i), dut_imm(i), 64'd0);
      chk($sformatf("%s dut%0d imm_type", tag, i), 64'(type_w[i]), 64'd7);
      chk($sformatf("%s dut%0d illegal", tag, i), 64'(illegal_w[i]), 64'd0);
    end
  endtask

  function automatic logic [6:0] pick_op(input int n);
    case (n)
      0: return 7'h13;  1: return 7'h03;  2: return 7'h67;  3: return 7'h0F;
      4: return 7'h23;  5: return 7'h63;  6: return 7'h37;  7: return 7'h17;
      8: return 7'h6F;  9: return 7'h73;  default: return 7'h33;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  typ;
    logic        ill;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    tbl[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    tbl[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    tbl[2]  = '{32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd3, 1'b0};
    tbl[3]  = '{32'h0000006F, 32'h00000000, 64'h0000000000000000, 3'd4, 1'b0};
    tbl[4]  = '{32'h300FD073, 32'h0000001F, 64'h000000000000001F, 3'd5, 1'b0};
    tbl[5]  = '{32'h00309093, 32'h00000003, 64'h0000000000000003, 3'd6, 1'b0};
    tbl[6]  = '{32'h0000007F, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b1};
    tbl[7]  = '{32'h00000033, 32'h00000000, 64'h0000000000000000, 3'd7, 1'b0};
    tbl[8]  = '{32'h02009093, 32'h00000000, 64'h0000000000000020, 3'd6, 1'b0};
    tbl[9]  = '{32'hFE112C23, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b0};
    tbl[10] = '{32'h34009073, 32'h00000340, 64'h0000000000000340, 3'd0, 1'b0};
    tbl[11] = '{32'h80000067, 32'hFFFFF800, 64'hFFFFFFFFFFFFF800, 3'd0, 1'b0};
    tbl[12] = '{32'h80000017, 32'h80000000, 64'hFFFFFFFF80000000, 3'd3, 1'b0};
    tbl[13] = '{32'h7FF00003, 32'h000007FF, 64'h00000000000007FF, 3'd0, 1'b0};
    tbl[14] = '{32'h0FF0000F, 32'h000000FF, 64'h00000000000000FF, 3'd0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_type_in = '0; out_ready = 1'b1;
    for (int i = 0; i < N_DUT; i++) occ[i] = 0;
    repeat (2) @(negedge clk);
    chk_reset_values("reset");
    rst = 1'b0;

    // Back-to-back directed vectors; each DUT emits entry c-STAGES on consecutive cycles.
    for (int c = 0; c < NV + 3; c++) begin
      if (c < NV) drive(1'b1, tbl[c].instr, tbl[c].typ, 1'b1, 1'b0);
      else        drive(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < N_DUT; i++) begin
        int k;
        k = c - st_of(i);
        if (k >= 0 && k < NV) begin
          chk($sformatf("vec%0d dut%0d out_valid", k, i), 64'(out_valid_w[i]), 64'd1);
          chk($sformatf("vec%0d dut%0d imm", k, i), dut_imm(i),
              (xl_of(i) == 32) ? {32'd0, tbl[k].imm32} : tbl[k].imm64);
          chk($sformatf("vec%0d dut%0d type", k, i), 64'(type_w[i]), 64'(tbl[k].typ));
          chk($sformatf("vec%0d dut%0d illegal", k, i), 64'(illegal_w[i]),
              64'(ad_of(i) ? tbl[k].ill : 1'b0));
        end else begin
          chk($sformatf("vec idle c%0d dut%0d out_valid", c, i), 64'(out_valid_w[i]), 64'd0);
        end
      end
      advance();
    end

    // Backpressure on the two-stage pipe: out_ready low for 4 cycles, 3 instructions offered.
    drive(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b0);
    chk("bp accept A in_ready", 64'(in_ready_w[1]), 64'd1);
    advance();
    drive(1'b1, 32'h123450B7, 3'd3, 1'b0, 1'b0);
    chk("bp accept B in_ready", 64'(in_ready_w[1]), 64'd1);
    chk("bp latency out_valid", 64'(out_valid_w[1]), 64'd0);
    advance();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h0000007F, 3'd7, 1'b0, 1'b0);
      chk("bp full in_ready", 64'(in_ready_w[1]), 64'd0);
      chk("bp hold out_valid", 64'(out_valid_w[1]), 64'd1);
      chk("bp hold imm", 64'(imm_1), 64'hFFFFFFFF);
      chk("bp hold type", 64'(type_w[1]), 64'd0);
      advance();
    end
    drive(1'b1, 32'h0000007F, 3'd7, 1'b1, 1'b0);
    chk("bp release in_ready", 64'(in_ready_w[1]), 64'd1);
    chk("bp out A imm", 64'(imm_1), 64'hFFFFFFFF);
    advance();
    drive(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("bp out B valid", 64'(out_valid_w[1]), 64'd1);
    chk("bp out B imm", 64'(imm_1), 64'h12345000);
    chk("bp out B type", 64'(type_w[1]), 64'd3);
    advance();
    drive(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("bp out C valid", 64'(out_valid_w[1]), 64'd1);
    chk("bp out C imm", 64'(imm_1), 64'd0);
    chk("bp out C type", 64'(type_w[1]), 64'd7);
    chk("bp out C illegal", 64'(illegal_w[1]), 64'd1);
    advance();
    drive(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    chk("bp drained out_valid", 64'(out_valid_w[1]), 64'd0);
    advance();

    // Flush with two entries in flight and a third offered.
    drive(1'b1, 32'h00309093, 3'd6, 1'b0, 1'b0); advance();
    drive(1'b1, 32'h0000006F, 3'd4, 1'b0, 1'b0); advance();
    drive(1'b1, 32'hFE000EE3, 3'd2, 1'b1, 1'b1);
    for (int i = 0; i < N_DUT; i++)
      chk($sformatf("flush dut%0d in_ready", i), 64'(in_ready_w[i]), 64'd0);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
      for (int i = 0; i < N_DUT; i++)
        chk($sformatf("post-flush c%0d dut%0d out_valid", c, i), 64'(out_valid_w[i]), 64'd0);
      advance();
    end

    // Randomised traffic, with an asynchronous reset pulse in the middle.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        drive(1'b1, 32'hFFF00093, 3'd0, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h02009093, 3'd6, 1'b0, 1'b0); advance();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 chk_reset_values("async reset");
        for (int i = 0; i < N_DUT; i++) occ[i] = 0;
        @(negedge clk);
        rst = 1'b0;
      end
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[6:0] = pick_op($urandom_range(0, 10));
      drive(($urandom_range(0, 3) != 0), r, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
